// File: rtl/exe_mac_if.sv
// exe_mac_if: ID/EXE-to-MAC-unit bundle.
//   master (upstream): drives i_valid, i_op, i_DatA, i_DatB, i_imm, i_Robj; samples o_stall, o_valid, o_result, o_Robj
//   slave (exe_mac_unit): the reverse directions
interface exe_mac_if #(parameter int REG_IDX_W = 4);
    logic                 i_valid;
    logic [2:0]           i_op;
    logic [31:0]          i_DatA;
    logic [31:0]          i_DatB;
    logic [31:0]          i_imm;
    logic [REG_IDX_W-1:0] i_Robj;
    logic                 o_stall;
    logic                 o_valid;
    logic [31:0]          o_result;
    logic [REG_IDX_W-1:0] o_Robj;
    modport master (
        output i_valid, i_op, i_DatA, i_DatB, i_imm, i_Robj,
        input  o_stall, o_valid, o_result, o_Robj
    );
    modport slave (
        input  i_valid, i_op, i_DatA, i_DatB, i_imm, i_Robj,
        output o_stall, o_valid, o_result, o_Robj
    );
endinterface

// File: rtl/exe_mac_unit.sv
// exe_mac_unit: single-cycle ALU ops plus a 32-step shift-add multiplier with accumulator.
//   clk, rst (async active-high); bus (exe_mac_if.slave): i_valid/i_op/i_DatA/i_DatB/i_imm/i_Robj in,
//   o_stall (hold ID/EXE), o_valid (1-cycle result pulse), o_result, o_Robj out.
//   Define EXE_MAC_SAT_EN to make the MAC addition saturate as signed 32-bit; otherwise it wraps.
module exe_mac_unit #(
    parameter int REG_IDX_W = 4
) (
    input logic      clk,
    input logic      rst,
    exe_mac_if.slave bus
);
    typedef enum logic {IDLE, MULT} state_t;
    localparam logic [2:0] OP_NOP = 3'b000, OP_ADD = 3'b001, OP_SUB = 3'b010, OP_ADDI = 3'b011,
                           OP_MUL = 3'b100, OP_MAC = 3'b101, OP_CLR = 3'b110, OP_RD = 3'b111;
    state_t               state;
    logic [4:0]           step;
    logic [31:0]          mcand;
    logic [31:0]          mplier;
    logic [31:0]          prod;
    logic [31:0]          acc;
    logic                 is_mac;
    logic [REG_IDX_W-1:0] robj_q;
    logic                 valid_q;
    logic [31:0]          result_q;
    logic [REG_IDX_W-1:0] robj_out;
    logic [31:0]          prod_next;
    logic [31:0]          mac_sum;
    logic [31:0]          alu_res;
`ifdef EXE_MAC_SAT_EN
    logic [32:0]          mac_wide;
`endif
    always_comb begin
        prod_next = prod + (mplier[0] ? mcand : 32'd0);
`ifdef EXE_MAC_SAT_EN
        // sign-extended sum: bits 32 and 31 disagree exactly on signed overflow
        mac_wide = {acc[31], acc} + {prod_next[31], prod_next};
        mac_sum  = (mac_wide[32] != mac_wide[31]) ? (mac_wide[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                                                  : mac_wide[31:0];
`else
        mac_sum  = acc + prod_next;
`endif
        alu_res = (bus.i_op == OP_ADD)  ? bus.i_DatA + bus.i_DatB :
                  (bus.i_op == OP_SUB)  ? bus.i_DatA - bus.i_DatB :
                  (bus.i_op == OP_ADDI) ? bus.i_DatA + bus.i_imm  :
                  (bus.i_op == OP_RD)   ? acc : 32'd0;
    end
    assign bus.o_stall  = (state == MULT);
    assign bus.o_valid  = valid_q;
    assign bus.o_result = result_q;
    assign bus.o_Robj   = robj_out;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            step     <= '0;
            mcand    <= '0;
            mplier   <= '0;
            prod     <= '0;
            acc      <= '0;
            is_mac   <= 1'b0;
            robj_q   <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            robj_out <= '0;
        end else begin
            valid_q <= 1'b0;
            if (state == IDLE) begin
                if (bus.i_valid && bus.i_op != OP_NOP) begin
                    if (bus.i_op == OP_MUL || bus.i_op == OP_MAC) begin
                        state  <= MULT;
                        mcand  <= bus.i_DatA;
                        mplier <= bus.i_DatB;
                        prod   <= '0;
                        step   <= '0;
                        is_mac <= (bus.i_op == OP_MAC);
                        robj_q <= bus.i_Robj;
                    end else begin
                        valid_q  <= 1'b1;
                        result_q <= alu_res;
                        robj_out <= bus.i_Robj;
                        if (bus.i_op == OP_CLR) acc <= '0;
                    end
                end
            end else begin
                prod   <= prod_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                step   <= step + 5'd1;
                // step 31 is the 32nd add; its sum is the final product
                if (step == 5'd31) begin
                    state    <= IDLE;
                    valid_q  <= 1'b1;
                    result_q <= is_mac ? mac_sum : prod_next;
                    robj_out <= robj_q;
                    if (is_mac) acc <= mac_sum;
                end
            end
        end
    end
endmodule

// File: tb/tb_exe_mac_unit.sv
// tb_exe_mac_unit: scoreboard bench for exe_mac_unit with an arithmetic reference model.
module tb_exe_mac_unit;
    localparam logic [2:0] OP_NOP = 3'b000, OP_ADD = 3'b001, OP_SUB = 3'b010, OP_ADDI = 3'b011,
                           OP_MUL = 3'b100, OP_MAC = 3'b101, OP_CLR = 3'b110, OP_RD = 3'b111;
    typedef struct {
        logic [31:0] res;
        logic [3:0]  robj;
        int          due;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    exe_mac_if #(.REG_IDX_W(4)) bus();
    exe_mac_unit #(.REG_IDX_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          busy = 0;
    logic [31:0] acc_m = 0;
    bit          accepted;
    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction
    function automatic logic [31:0] mac_ref(logic [31:0] a, logic [31:0] p);
        longint s;
        s = longint'($signed(a)) + longint'($signed(p));
`ifdef EXE_MAC_SAT_EN
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction
    function automatic void model();
        logic [63:0] pr;
        logic [31:0] r;
        pr = {32'd0, bus.i_DatA} * {32'd0, bus.i_DatB};
        case (bus.i_op)
            OP_ADD:  q.push_back('{bus.i_DatA + bus.i_DatB, bus.i_Robj, cyc});
            OP_SUB:  q.push_back('{bus.i_DatA - bus.i_DatB, bus.i_Robj, cyc});
            OP_ADDI: q.push_back('{bus.i_DatA + bus.i_imm, bus.i_Robj, cyc});
            OP_MUL: begin
                busy = 32;
                q.push_back('{pr[31:0], bus.i_Robj, cyc + 32});
            end
            OP_MAC: begin
                busy = 32;
                r = mac_ref(acc_m, pr[31:0]);
                acc_m = r;
                q.push_back('{r, bus.i_Robj, cyc + 32});
            end
            OP_CLR: begin
                acc_m = 0;
                q.push_back('{32'd0, bus.i_Robj, cyc});
            end
            OP_RD:   q.push_back('{acc_m, bus.i_Robj, cyc});
            default: ;
        endcase
    endfunction
    // one clock: called at a negedge with inputs already driven, returns at the next negedge
    task automatic cycle();
        chk("stall", {31'd0, bus.o_stall}, {31'd0, busy > 0});
        @(posedge clk);
        cyc++;
        accepted = 0;
        if (rst) busy = 0;
        else if (busy > 0) busy--;
        else if (bus.i_valid) begin
            accepted = 1;
            model();
        end
        @(negedge clk);
    endtask
    task automatic idle(int n);
        bus.i_valid = 1'b0;
        repeat (n) cycle();
    endtask
    task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] imm, logic [3:0] robj);
        int n;
        bus.i_valid = 1'b1;
        bus.i_op    = op;
        bus.i_DatA  = a;
        bus.i_DatB  = b;
        bus.i_imm   = imm;
        bus.i_Robj  = robj;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!accepted && n < 100);
        if (!accepted) begin
            errors++;
            $display("FAIL accept: op %0d not accepted within 100 cycles", op);
        end
        bus.i_valid = 1'b0;
    endtask
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (bus.o_valid) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_valid: got result %h, expected no pulse (cycle %0d)", bus.o_result, cyc);
                    end else begin
                        e = q.pop_front();
                        chk("result", bus.o_result, e.res);
                        chk("robj", {28'd0, bus.o_Robj}, {28'd0, e.robj});
                        chk("timing", cyc, e.due);
                    end
                end else if (q.size() > 0 && q[0].due <= cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_valid: got no pulse, expected result %h at cycle %0d", q[0].res, q[0].due);
                    void'(q.pop_front());
                end
            end
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.i_valid = 1'b0;
        bus.i_op = OP_NOP;
        bus.i_DatA = 0;
        bus.i_DatB = 0;
        bus.i_imm = 0;
        bus.i_Robj = 0;
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'd0, bus.o_stall}, 32'd0);
        chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst_result", bus.o_result, 32'd0);
        chk("rst_robj", {28'd0, bus.o_Robj}, 32'd0);
        rst = 1'b0;
        issue(OP_ADD, 5, 7, 0, 3);
        idle(2);
        issue(OP_MUL, 32'h0000_1234, 32'h0000_0010, 0, 5);
        idle(34);
        issue(OP_CLR, 0, 0, 0, 1);
        issue(OP_MAC, 3, 4, 0, 2);
        issue(OP_MAC, 32'hFFFF_FFFF, 2, 0, 2);
        issue(OP_CLR, 0, 0, 0, 1);
        issue(OP_MAC, 32'h7FFF_FFF0, 1, 0, 6);
        issue(OP_MAC, 32'h20, 1, 0, 6);
        issue(OP_SUB, 0, 1, 0, 7);
        issue(OP_ADDI, 32'hFFFF_FFFF, 0, 2, 8);
        issue(OP_NOP, 1, 2, 3, 9);
        idle(2);
        issue(OP_MAC, 9, 9, 0, 4);
        idle(10);
        rst = 1'b1;
        q.delete();
        busy = 0;
        acc_m = 0;
        #1;
        chk("abort_stall", {31'd0, bus.o_stall}, 32'd0);
        chk("abort_valid", {31'd0, bus.o_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(40);
        issue(OP_RD, 0, 0, 0, 10);
        issue(OP_MUL, 32'hDEAD_BEEF, 32'h1234_5678, 0, 11);
        issue(OP_ADD, 32'hFFFF_FFFF, 1, 0, 12);
        idle(2);
        for (int i = 0; i < 120; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? 32'h7FFF_0000 + $urandom_range(0, 65535) : $urandom;
            b = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 16) : $urandom;
            issue(3'($urandom_range(0, 7)), a, b, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(40);
        chk("queue_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/exe_mac_unit.md
EXE_MAC_UNIT -- requirements
Module: exe_mac_unit

Interface
REQ-001 Parameter REG_IDX_W, default 4, SHALL set the width of the destination register index.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 i_valid  input  1  SHALL flag a valid operation on the i_* inputs from the ID/EXE register.
REQ-005 i_op  input  3  SHALL select the operation: 000 NOP, 001 ADD, 010 SUB, 011 ADDI, 100 MUL, 101 MAC, 110 CLRACC, 111 RDACC.
REQ-006 i_DatA, i_DatB, i_imm  input  32 each  SHALL carry the operands and the immediate.
REQ-007 i_Robj  input  REG_IDX_W  SHALL carry the destination register index.
REQ-008 o_stall  output  1  SHALL drive the ID/EXE register EN; 1 = hold.
REQ-009 o_valid  output  1  SHALL pulse for one cycle when o_result is valid.
REQ-010 o_result  output  32  SHALL carry the operation result.
REQ-011 o_Robj  output  REG_IDX_W  SHALL carry the destination index matching o_result.

Function
REQ-012 The unit SHALL have states IDLE and MULT; it accepts an operation only in IDLE with i_valid=1, at edge E.
REQ-013 ADD/SUB/ADDI SHALL compute A+B, A-B, A+imm modulo 2^32; o_result and o_valid=1 appear in the cycle after E.
REQ-014 CLRACC SHALL set acc to 0 and return 0; RDACC SHALL return acc unchanged; latency as REQ-013.
REQ-015 NOP SHALL be accepted with no o_valid pulse and no state change.
REQ-016 MUL/MAC SHALL enter MULT at E and perform 32 shift-add steps, one per cycle, on edges E+1..E+32, producing the low 32 bits of A*B.
REQ-017 At edge E+32 the unit SHALL return to IDLE and pulse o_valid with the result in the cycle after E+32.
REQ-018 MUL SHALL return the low 32 bits of A*B; MAC SHALL set acc to acc + that value and return the new acc.
REQ-019 o_stall SHALL equal (state==MULT), combinationally: high for exactly the 32 cycles following E..E+31.
REQ-020 i_valid and all i_* SHALL be ignored in MULT; operands SHALL be captured at E.
REQ-021 The instruction held upstream during a stall SHALL be accepted exactly once, at edge E+33 at the earliest.
REQ-022 o_valid SHALL be 0 in every cycle not named in REQ-013/014/017; o_result and o_Robj SHALL hold their last values.
REQ-023 An o_valid pulse and a new acceptance in the same cycle SHALL both take effect with no lost result.

Reset
REQ-024 On rst=1, asynchronously: state=IDLE, step counter=0, acc=0, o_valid=0, o_stall=0, o_result=0, o_Robj=0.
REQ-025 Reset during MULT SHALL abort the operation, produce no o_valid pulse, and leave acc=0.
REQ-026 The first acceptance SHALL be possible at the first rising edge after rst deasserts.

Configuration
REQ-027 Macro EXE_MAC_SAT_EN defined: the MAC addition SHALL saturate as signed 32-bit, to 0x7FFFFFFF on positive overflow and 0x80000000 on negative overflow.
REQ-028 EXE_MAC_SAT_EN undefined: the MAC addition SHALL wrap modulo 2^32.
REQ-029 ADD/SUB/ADDI SHALL wrap regardless of the macro.

Verification
REQ-030 ADD A=5, B=7, Robj=3 -> next cycle o_valid=1, o_result=12, o_Robj=3; o_stall stays 0.
REQ-031 MUL A=0x00001234, B=0x00000010 -> o_stall high 32 cycles, then o_valid=1, o_result=0x00012340.
REQ-032 CLRACC; MAC 3*4; MAC 0xFFFFFFFF*2 -> results 0, 12, 10.
REQ-033 CLRACC; MAC 0x7FFFFFF0*1; MAC 0x20*1 -> second result 0x7FFFFFFF with EXE_MAC_SAT_EN, 0x80000010 without.
REQ-034 rst pulsed 10 cycles into MUL -> o_stall=0 and o_valid=0 immediately, no later pulse; next RDACC -> 0.
REQ-035 ADD held on i_* with i_valid=1 throughout a MUL stall -> exactly one ADD o_valid pulse, after the MUL result.
